// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and the fetch queue entry type
package fetch_unit_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory port plus decode valid/ready handshake
interface fetch_if;
  import fetch_unit_pkg::*;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_instr;
  logic if_valid;
  logic if_ready;
  logic [WORD_W-1:0] if_instr;
  logic [WORD_W-1:0] if_pc;
  logic [WORD_W-1:0] if_pc_plus4;
  modport master (output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, input imem_instr, if_ready);
  modport slave (input imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, output imem_instr, if_ready);
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: 2-entry {pc,instr} FIFO, flush beats push/pop, head zeroed when empty
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output logic         valid,
  output fetch_entry_t head
);
  fetch_entry_t e0, e1;
  logic [1:0] wr;
  always_comb begin
    wr = count - {1'b0, pop};
    valid = count != 2'd0;
    head = valid ? e0 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      // shift on pop first so a same-cycle push lands in the freed slot
      if (pop) e0 <= e1;
      if (push && wr == 2'd0) e0 <= din;
      if (push && wr == 2'd1) e1 <= din;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner feeding decode through a 2-entry fetch queue with redirect and halt
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  fetch_if.master           bus,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              halt,
  output logic              misalign_err
);
  logic [WORD_W-1:0] pc;
  logic halted, push, pop, valid;
  logic [1:0] count;
  fetch_entry_t head;
  always_comb begin
    pop = valid && bus.if_ready && !redirect_valid;
    push = !halted && !redirect_valid && (count < 2'(QUEUE_DEPTH) || (valid && bus.if_ready));
    bus.imem_addr = pc;
    bus.if_valid = valid;
    bus.if_instr = valid ? head.instr : INSTR_NOP;
    bus.if_pc = head.pc;
    bus.if_pc_plus4 = valid ? head.pc + PC_INC : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      halted <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      pc <= redirect_valid ? {redirect_target[WORD_W-1:2], 2'b00} : push ? pc + PC_INC : pc;
      halted <= halted | halt;
      misalign_err <= misalign_err | (redirect_valid && |redirect_target[1:0]);
    end
  end
  fetch_queue u_queue (
    .clk  (clk),
    .rst  (reset),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ('{pc: pc, instr: bus.imem_instr}),
    .count(count),
    .valid(valid),
    .head (head)
  );
endmodule
